// File: rtl/adrf_spi_sched.sv
// Two-requester round-robin SPI master for the ADRF6612 3-wire register bus.
// One 16-bit frame per grant, with SDIO turnaround and 8-bit read capture on read frames.
module adrf_spi_sched #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 4
) (
    input  logic        clk,
    input  logic        resync_n,
    input  logic [1:0]  req,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_sdo,
    output logic        spi_oe,
    input  logic        spi_sdi
);

    localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_END   = 16'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  bit_idx;
    logic [15:0] sreg;
    logic [7:0]  rsh;
    logic        is_read;
    logic        prio;
    logic        sel;

    // prio names the requester that wins when both ask at once
    always_comb begin
        sel = req[1];
        if (req == 2'b11) begin
            sel = prio;
        end
    end

    always_ff @(posedge clk or negedge resync_n) begin
        if (!resync_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            sreg     <= '0;
            rsh      <= '0;
            is_read  <= 1'b0;
            prio     <= 1'b0;
            gnt      <= '0;
            done     <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_sdo  <= 1'b0;
            spi_oe   <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        gnt      <= sel ? 2'b10 : 2'b01;
                        prio     <= ~sel;
                        sreg     <= sel ? cmd1 : cmd0;
                        is_read  <= sel ? cmd1[15] : cmd0[15];
                        spi_sdo  <= sel ? cmd1[15] : cmd0[15];
                        spi_cs_n <= 1'b0;
                        spi_oe   <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_END) begin
                        cnt     <= '0;
                        bit_idx <= 4'd15;
                        state   <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == DIV_END) begin
                        cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            // End of a high phase: sample read data, then open the next bit's low phase
                            spi_sclk <= 1'b0;
                            if (is_read && bit_idx <= 4'd7) begin
                                rsh <= {rsh[6:0], spi_sdi};
                            end
                            if (bit_idx == 4'd0) begin
                                state <= ST_HOLD;
                            end else begin
                                bit_idx <= bit_idx - 4'd1;
                                sreg    <= {sreg[14:0], 1'b0};
                                if (is_read && bit_idx <= 4'd8) begin
                                    spi_oe  <= 1'b0;
                                    spi_sdo <= 1'b0;
                                end else begin
                                    spi_sdo <= sreg[14];
                                end
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_END) begin
                        cnt      <= '0;
                        spi_cs_n <= 1'b1;
                        spi_oe   <= 1'b0;
                        spi_sdo  <= 1'b0;
                        gnt      <= '0;
                        done     <= gnt;
                        if (is_read) begin
                            rdata <= rsh;
                        end
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_END) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adrf_spi_sched.sv
// Directed scoreboard bench for adrf_spi_sched: a default-timing instance and a fastest-timing instance,
// each with a small ADRF model that records SDO on SCLK rises and returns read data on SCLK falls.
module tb_adrf_spi_sched;

    logic        clk = 1'b0;
    logic        resync_n;
    logic [1:0]  req_r  [2];
    logic [15:0] cmd0_r [2];
    logic [15:0] cmd1_r [2];
    logic        sdi_r  [2];
    logic [1:0]  gnt_w  [2];
    logic [1:0]  done_w [2];
    logic [7:0]  rdata_w[2];
    logic        busy_w [2];
    logic        csn_w  [2];
    logic        sclk_w [2];
    logic        sdo_w  [2];
    logic        oe_w   [2];

    always #5 clk = ~clk;

    adrf_spi_sched dut_a (
        .clk(clk), .resync_n(resync_n), .req(req_r[0]), .cmd0(cmd0_r[0]), .cmd1(cmd1_r[0]),
        .gnt(gnt_w[0]), .done(done_w[0]), .rdata(rdata_w[0]), .busy(busy_w[0]),
        .spi_cs_n(csn_w[0]), .spi_sclk(sclk_w[0]), .spi_sdo(sdo_w[0]), .spi_oe(oe_w[0]),
        .spi_sdi(sdi_r[0])
    );

    adrf_spi_sched #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP(1)) dut_f (
        .clk(clk), .resync_n(resync_n), .req(req_r[1]), .cmd0(cmd0_r[1]), .cmd1(cmd1_r[1]),
        .gnt(gnt_w[1]), .done(done_w[1]), .rdata(rdata_w[1]), .busy(busy_w[1]),
        .spi_cs_n(csn_w[1]), .spi_sclk(sclk_w[1]), .spi_sdo(sdo_w[1]), .spi_oe(oe_w[1]),
        .spi_sdi(sdi_r[1])
    );

    typedef struct {
        logic [1:0]  who;
        logic [7:0]  rd;
        logic [15:0] frame;
        bit          is_read;
        int          cs_low;
        int          lat;
        int          oe_off;
        int          gap;
        int          period;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_err    = 0;

    // Bus monitor and ADRF model state, all owned by the monitor process
    int          cyc = 0;
    logic [15:0] cap        [2];
    int          rises      [2];
    int          low_cnt    [2];
    int          high_cnt   [2];
    int          last_low   [2];
    int          last_high  [2];
    int          gnt_cyc    [2];
    int          done_cyc   [2];
    int          oe_fall_cyc[2];
    bit          oe_fell    [2];
    int          g1_count   [2];
    logic        prev_cs    [2];
    logic        prev_sclk  [2];
    logic        prev_oe    [2];
    logic [1:0]  prev_gnt   [2];
    logic [7:0]  rd_val     [2];
    int          prev_done  [2];

    always @(negedge clk) begin
        logic [2:0] bi;
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!resync_n) sdi_r[i] = 1'b0;
            if (csn_w[i] === 1'b0 && prev_cs[i] === 1'b1) begin
                cap[i]   = '0;
                rises[i] = 0;
            end
            if (csn_w[i] === 1'b1) begin
                high_cnt[i] = high_cnt[i] + 1;
                if (low_cnt[i] != 0) begin
                    last_low[i] = low_cnt[i];
                    low_cnt[i]  = 0;
                end
            end else begin
                low_cnt[i] = low_cnt[i] + 1;
                if (high_cnt[i] != 0) begin
                    last_high[i] = high_cnt[i];
                    high_cnt[i]  = 0;
                end
            end
            if (sclk_w[i] === 1'b1 && prev_sclk[i] === 1'b0) begin
                cap[i]   = {cap[i][14:0], sdo_w[i]};
                rises[i] = rises[i] + 1;
            end
            if (sclk_w[i] === 1'b0 && prev_sclk[i] === 1'b1 && rises[i] >= 8 && rises[i] < 16) begin
                bi       = 3'(15 - rises[i]);
                sdi_r[i] = rd_val[i][bi];
            end
            if (gnt_w[i] != 2'b00 && prev_gnt[i] == 2'b00) begin
                gnt_cyc[i] = cyc;
                oe_fell[i] = 1'b0;
            end
            if (gnt_w[i][1] === 1'b1 && prev_gnt[i][1] !== 1'b1) g1_count[i] = g1_count[i] + 1;
            if (oe_w[i] === 1'b0 && prev_oe[i] === 1'b1 && csn_w[i] === 1'b0) begin
                oe_fell[i]     = 1'b1;
                oe_fall_cyc[i] = cyc;
            end
            if (done_w[i] != 2'b00) done_cyc[i] = cyc;
            prev_cs[i]   = csn_w[i];
            prev_sclk[i] = sclk_w[i];
            prev_oe[i]   = oe_w[i];
            prev_gnt[i]  = gnt_w[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void push(input logic [1:0] who, input logic [7:0] rd, input logic [15:0] cmd,
                                 input bit fast, input int gap, input int period);
        exp_t e;
        e.who     = who;
        e.rd      = rd;
        e.is_read = cmd[15];
        e.frame   = cmd[15] ? {cmd[15:8], 8'h00} : cmd;
        e.cs_low  = fast ? 34 : 132;
        e.lat     = fast ? 34 : 132;
        e.oe_off  = fast ? 17 : 66;
        e.gap     = gap;
        e.period  = period;
        q.push_back(e);
    endfunction

    task automatic check_reset(input int i);
        check("rst_cs_n",  32'(csn_w[i]),   32'd1);
        check("rst_sclk",  32'(sclk_w[i]),  32'd0);
        check("rst_sdo",   32'(sdo_w[i]),   32'd0);
        check("rst_oe",    32'(oe_w[i]),    32'd0);
        check("rst_gnt",   32'(gnt_w[i]),   32'd0);
        check("rst_done",  32'(done_w[i]),  32'd0);
        check("rst_rdata", 32'(rdata_w[i]), 32'd0);
        check("rst_busy",  32'(busy_w[i]),  32'd0);
    endtask

    task automatic wait_gnt(input int i, input logic [1:0] val, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (gnt_w[i] === val) seen = 1'b1;
        end
        check("gnt_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_done(input int i, input int budget);
        bit   seen = 1'b0;
        exp_t e;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done_w[i] != 2'b00) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (!seen || q.size() == 0) return;
        e = q.pop_front();
        check("done_who", 32'(done_w[i]), 32'(e.who));
        check("rdata",    32'(rdata_w[i]), 32'(e.rd));
        check("frame",    32'(cap[i]), 32'(e.frame));
        @(negedge clk);
        check("done_pulse", 32'(done_w[i]), 32'd0);
        check("rdata_hold", 32'(rdata_w[i]), 32'(e.rd));
        check("cs_low",     32'(last_low[i]), 32'(e.cs_low));
        check("latency",    32'(done_cyc[i] - gnt_cyc[i]), 32'(e.lat));
        if (e.is_read) check("oe_turn", 32'(oe_fall_cyc[i] - gnt_cyc[i]), 32'(e.oe_off));
        else           check("oe_held", 32'(oe_fell[i]), 32'd0);
        if (e.gap != 0)    check("cs_gap", 32'(last_high[i]), 32'(e.gap));
        if (e.period != 0) check("period", 32'(done_cyc[i] - prev_done[i]), 32'(e.period));
        prev_done[i] = done_cyc[i];
    endtask

    task automatic wait_bit5(input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (rises[0] == 11 && sclk_w[0] === 1'b1) seen = 1'b1;
        end
        check("bit5_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int g1_base;
        for (int i = 0; i < 2; i++) begin
            req_r[i]  = 2'b00;
            cmd0_r[i] = '0;
            cmd1_r[i] = '0;
            rd_val[i] = '0;
        end
        resync_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        resync_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy_w[0]), 32'd0);

        $display("[TB] write frame on requester 0");
        cmd0_r[0] = 16'h0A5C;
        req_r[0]  = 2'b01;
        push(2'b01, 8'h00, 16'h0A5C, 1'b0, 0, 0);
        wait_gnt(0, 2'b01, 20);
        check("frame_busy", 32'(busy_w[0]), 32'd1);
        wait_done(0, 400);
        req_r[0] = 2'b00;

        $display("[TB] read frame on requester 1");
        rd_val[0] = 8'hC3;
        cmd1_r[0] = 16'h8300;
        req_r[0]  = 2'b10;
        push(2'b10, 8'hC3, 16'h8300, 1'b0, 0, 0);
        wait_done(0, 400);
        req_r[0] = 2'b00;
        repeat (10) @(negedge clk);

        $display("[TB] tie from reset with cmd changes mid-frame");
        #3 resync_n = 1'b0;
        #1 check_reset(0);
        cmd0_r[0] = 16'h1234;
        cmd1_r[0] = 16'h7E81;
        req_r[0]  = 2'b11;
        @(negedge clk);
        resync_n = 1'b1;
        push(2'b01, 8'h00, 16'h1234, 1'b0, 0, 0);
        push(2'b10, 8'h00, 16'h7E81, 1'b0, 5, 0);
        wait_gnt(0, 2'b01, 20);
        cmd0_r[0] = 16'h55AA;
        push(2'b01, 8'h00, 16'h55AA, 1'b0, 5, 0);
        wait_done(0, 400);
        wait_gnt(0, 2'b10, 20);
        cmd1_r[0] = 16'h6C39;
        push(2'b10, 8'h00, 16'h6C39, 1'b0, 5, 0);
        wait_done(0, 400);
        wait_done(0, 400);
        wait_done(0, 400);
        req_r[0] = 2'b00;
        repeat (10) @(negedge clk);

        $display("[TB] reset during bit 5, then three single-requester frames");
        cmd0_r[0] = 16'h3C96;
        req_r[0]  = 2'b01;
        wait_gnt(0, 2'b01, 20);
        wait_bit5(200);
        #3 resync_n = 1'b0;
        #1 check_reset(0);
        repeat (2) @(negedge clk);
        check("rst_no_done", 32'(done_w[0]), 32'd0);
        resync_n = 1'b1;
        g1_base  = g1_count[0];
        push(2'b01, 8'h00, 16'h3C96, 1'b0, 0, 0);
        push(2'b01, 8'h00, 16'h3C96, 1'b0, 5, 137);
        push(2'b01, 8'h00, 16'h3C96, 1'b0, 5, 137);
        wait_done(0, 400);
        wait_done(0, 400);
        wait_done(0, 400);
        req_r[0] = 2'b00;
        check("req1_never", 32'(g1_count[0] - g1_base), 32'd0);
        repeat (10) @(negedge clk);

        $display("[TB] fastest timing instance");
        rd_val[1] = 8'h5A;
        cmd0_r[1] = 16'h9100;
        req_r[1]  = 2'b01;
        push(2'b01, 8'h5A, 16'h9100, 1'b1, 0, 0);
        wait_done(1, 200);
        req_r[1]  = 2'b00;
        repeat (4) @(negedge clk);
        cmd1_r[1] = 16'h2BD4;
        req_r[1]  = 2'b10;
        push(2'b10, 8'h5A, 16'h2BD4, 1'b1, 0, 0);
        wait_done(1, 200);
        req_r[1] = 2'b00;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/adrf_spi_sched.md
# adrf_spi_sched

Arbitrated SPI master for the ADRF6612 3-wire register bus (CS, SCLK, bidirectional SDIO). Two requesters share the bus: requester 0 is the host command path and requester 1 is the local power-up/retune sequencer. The block serializes one 16-bit frame per grant, turns the SDIO bus around for reads, and returns read data and a completion pulse. It replaces direct pass-through of the MCU SPI onto the ADRF pins.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles (min 1).
- CS_SETUP, 2: clk cycles from CS low to first SCLK rise phase (min 1).
- CS_HOLD, 2: clk cycles from last SCLK fall to CS high (min 1).
- GAP, 4: minimum clk cycles CS stays high after a frame (min 1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resync_n  in  1  reset, asynchronous, active-low.
- req  in  2  level request per requester; held until its done pulse.
- cmd0  in  16  requester 0 frame; [15]=R/W (1=read), [14:8]=addr, [7:0]=wdata.
- cmd1  in  16  requester 1 frame, same format.
- gnt  out  2  one-hot grant, high from grant through the end of HOLD.
- done  out  2  one-cycle completion pulse to the granted requester.
- rdata  out  8  read data of the last read frame; updated only at done.
- busy  out  1  high in every state except IDLE.
- spi_cs_n  out  1  ADRF chip select, active low.
- spi_sclk  out  1  ADRF clock, idle low (mode 0).
- spi_sdo  out  1  SDIO drive value.
- spi_oe  out  1  SDIO output enable (1 = master drives).
- spi_sdi  in  1  SDIO sampled value.

## Operation
- Reset values: spi_cs_n=1, spi_sclk=0, spi_sdo=0, spi_oe=0, gnt=0, done=0, rdata=0, busy=0. Round-robin pointer favors requester 0.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: if any req is high, grant per round-robin. Requester 0 wins a tie after reset. Afterwards the requester not granted last wins a tie. Latch that requester's cmd into a 16-bit shift register and go to SETUP. The latched cmd is immune to later input changes.
- SETUP: spi_cs_n=0, spi_oe=1, spi_sdo=bit15. Lasts CS_SETUP cycles, then SHIFT.
- SHIFT: 16 bits, MSB first.
  - Each bit is CLK_DIV cycles with spi_sclk=0, then CLK_DIV cycles with spi_sclk=1.
  - spi_sdo changes only at the start of a low phase; the ADRF samples on the rising edge.
- Read frames (bit15=1):
  - Bits 15..8 are driven as above.
  - At the start of bit 7's low phase: spi_oe=0 and spi_sdo=0, held until IDLE.
  - spi_sdi is sampled on the last clk cycle of each high phase of bits 7..0 into a read shift register.
- Write frames keep spi_oe=1 through HOLD.
- After bit 0's high phase, go to HOLD: spi_sclk=0, spi_cs_n=0 for CS_HOLD cycles.
- GAP:
  - First cycle: spi_cs_n=1, spi_oe=0, gnt=0, done pulses for the granted requester.
  - rdata loads from the read shift register on read frames; it is unchanged on writes.
  - GAP lasts GAP cycles, then IDLE.
- A req drop mid-frame is ignored; the frame completes and done still pulses.
- A req still high in IDLE is treated as a new request. Requesters must deassert within GAP cycles of done.
- Async reset mid-frame forces reset values immediately. There is no done pulse and the frame is discarded. After release, arbitration restarts from requester 0 priority.

## Timing
- Grant latency: req seen high in IDLE at cycle T; gnt, busy, spi_cs_n=0 take effect at T+1.
- spi_cs_n low duration = CS_SETUP + 32·CLK_DIV + CS_HOLD cycles (defaults: 132).
- done asserts CS_SETUP + 32·CLK_DIV + CS_HOLD + 1 cycles after T (defaults: T+133).
- Minimum CS-high between back-to-back frames: GAP + 1 cycles (defaults: 5).
- Full frame period with defaults: 1 + 132 + 4 = 137 cycles.
- Read turnaround: spi_oe falls exactly 8·2·CLK_DIV cycles after SHIFT entry.
- rdata is valid in the same cycle done is high and holds until the next read's done.

## Test plan
- Write: req=01, cmd0=16'h0A5C, defaults → sdo at 16 SCLK rises = 0000_1010_0101_1100; spi_oe=1 throughout; cs_n low 132 cycles; done=01 at T+133; rdata stays 00.
- Read: req=10, cmd1=16'h8300, ADRF model drives 8'hC3 on falling edges → spi_oe drops at start of bit 7; done=10 with rdata=8'hC3.
- Tie: req=11 held continuously from reset → grants 0,1,0,1 in order; cs_n high exactly 5 cycles between frames; cmd0/cmd1 changed during frames do not alter the shifted bits.
- Reset during SHIFT bit 5 of a write → next edge all outputs at reset values, no done; after release with req=01 held, a fresh 132-cycle frame starts.
- Single requester, req=01 held, three frames → three done pulses 137 cycles apart; requester 1 is never granted.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, GAP=1 → SCLK = clk/2; cs_n low 34 cycles; read of 8'h5A is captured correctly.
